// File: rtl/cache_fill_unit_pkg.sv
// rtl/cache_fill_unit_pkg.sv - cache and LC-3b types shared by the L1 miss-handling logic
package cache_fill_unit_pkg;

   typedef logic [15:0]  lc3b_word;
   typedef logic [8:0]   cache_tag;
   typedef logic [2:0]   cache_way;
   typedef logic [2:0]   cache_index;
   typedef logic [127:0] cache_line;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WRITEBACK = 2'd1,
      FETCH     = 2'd2,
      INSTALL   = 2'd3
   } fill_state_t;

   // Same encoding the LRU tracker uses for its hit vector.
   function automatic logic [7:0] way_onehot(input cache_way way);
      logic [7:0] oh;
      oh      = '0;
      oh[way] = 1'b1;
      return oh;
   endfunction

endpackage

// File: rtl/cache_fill_unit.sv
// rtl/cache_fill_unit.sv - L1 miss engine: victim writeback, line fetch, install and LRU touch
module cache_fill_unit
   import cache_fill_unit_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        miss_req_i,
   input  lc3b_word    miss_addr_i,
   input  cache_way    victim_way_i,
   input  logic        victim_valid_i,
   input  logic        victim_dirty_i,
   input  cache_tag    victim_tag_i,
   input  cache_line   victim_data_i,
   output logic        pmem_read_o,
   output logic        pmem_write_o,
   output lc3b_word    pmem_address_o,
   output cache_line   pmem_wdata_o,
   input  cache_line   pmem_rdata_i,
   input  logic        pmem_resp_i,
   output logic [7:0]  fill_we_o,
   output cache_index  fill_index_o,
   output cache_tag    fill_tag_o,
   output cache_line   fill_data_o,
   output logic [7:0]  lru_touch_o,
   output logic        fill_done_o,
   output logic        busy_o
);

   fill_state_t state_q, state_d;
   lc3b_word    addr_q;
   cache_way    way_q;
   cache_tag    vtag_q;
   cache_line   vdata_q;
   cache_line   line_q;

   logic accept;
   assign accept = (state_q == IDLE) && miss_req_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         addr_q  <= '0;
         way_q   <= '0;
         vtag_q  <= '0;
         vdata_q <= '0;
         line_q  <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            // Offset bits are dropped here so the fetch address is already line aligned.
            addr_q  <= miss_addr_i & 16'hFFF0;
            way_q   <= victim_way_i;
            vtag_q  <= victim_tag_i;
            vdata_q <= victim_data_i;
         end
         if (state_q == FETCH && pmem_resp_i) begin
            line_q <= pmem_rdata_i;
         end
      end
   end

   always_comb begin
      state_d        = state_q;
      pmem_read_o    = 1'b0;
      pmem_write_o   = 1'b0;
      pmem_address_o = '0;
      pmem_wdata_o   = '0;
      fill_we_o      = '0;
      lru_touch_o    = '0;
      fill_done_o    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (miss_req_i) begin
               state_d = (victim_valid_i && victim_dirty_i) ? WRITEBACK : FETCH;
            end
         end
         WRITEBACK: begin
            pmem_write_o   = 1'b1;
            pmem_address_o = {vtag_q, addr_q[6:4], 4'h0};
            pmem_wdata_o   = vdata_q;
            if (pmem_resp_i) state_d = FETCH;
         end
         FETCH: begin
            pmem_read_o    = 1'b1;
            pmem_address_o = addr_q;
            if (pmem_resp_i) state_d = INSTALL;
         end
         INSTALL: begin
            fill_we_o   = way_onehot(way_q);
            lru_touch_o = way_onehot(way_q);
            fill_done_o = 1'b1;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign fill_index_o = addr_q[6:4];
   assign fill_tag_o   = addr_q[15:7];
   assign fill_data_o  = line_q;
   assign busy_o       = (state_q != IDLE);

endmodule
